// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and store buffer entry type
package mips_pkg;

  localparam int WORD_W    = 32;
  localparam int DM_IDX_HI = 9;
  localparam int DM_IDX_LO = 2;
  localparam int DM_IDX_W  = DM_IDX_HI - DM_IDX_LO + 1;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_select.sv
// rtl/sb_fwd_select.sv - youngest-match load forwarding search over buffered stores
module sb_fwd_select
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            valid_i,
  input  sb_entry_t [DEPTH-1:0]       entries_i,
  input  logic [PTR_W-1:0]            tail_i,
  input  logic [DM_IDX_W-1:0]         ld_idx_i,
  output logic                        hit_o,
  output logic [WORD_W-1:0]           data_o
);

  logic [PTR_W-1:0] idx;
  logic             unused_addr_bits;

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1);
  // later matches overwrite earlier ones so the youngest store wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_i - PTR_W'(k);
      if (valid_i[idx] &&
          entries_i[idx].addr[DM_IDX_HI:DM_IDX_LO] == ld_idx_i) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

  always_comb begin
    unused_addr_bits = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      unused_addr_bits = unused_addr_bits ^
                         (^{entries_i[k].addr[WORD_W-1:DM_IDX_HI+1],
                            entries_i[k].addr[DM_IDX_LO-1:0]});
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO between store path and data memory
module store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_sb,
  input  logic              sb_push,
  input  logic [WORD_W-1:0] sb_push_addr,
  input  logic [WORD_W-1:0] sb_push_data,
  output logic              sb_full,
  output logic              sb_empty,
  output logic [CNT_W-1:0]  sb_count,
  output logic              sb_overflow,
  input  logic [WORD_W-1:0] sb_ld_addr,
  output logic              sb_ld_hit,
  output logic [WORD_W-1:0] sb_ld_data,
  input  logic              dm_ready,
  output logic              dm_wr_en,
  output logic [WORD_W-1:0] dm_wr_addr,
  output logic [WORD_W-1:0] dm_wr_data
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  push_ok;
  logic                  pop;
  logic [DEPTH-1:0]      valid;
  logic [DM_IDX_W-1:0]   ld_idx;
  logic                  unused_ld_bits;

  assign sb_full     = (count_q == CNT_W'(DEPTH));
  assign sb_empty    = (count_q == '0);
  assign sb_count    = count_q;
  assign sb_overflow = ovf_q;

  // Acceptance looks only at the registered count, so a same-edge pop never
  // makes room and dm_ready has no path into the push side.
  assign push_ok = sb_push && !sb_full;
  assign dm_wr_en = !sb_empty && dm_ready;
  assign pop      = dm_wr_en;

  assign dm_wr_addr = mem_q[head_q].addr;
  assign dm_wr_data = mem_q[head_q].data;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) begin
      tail_d = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (sb_push && sb_full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_sb) begin
    if (rst_sb) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[tail_q] <= '{addr: sb_push_addr, data: sb_push_data};
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PTR_W-1:0] off;
    assign off      = PTR_W'(i) - head_q;
    assign valid[i] = (CNT_W'(off) < count_q);
  end

  assign ld_idx         = sb_ld_addr[DM_IDX_HI:DM_IDX_LO];
  assign unused_ld_bits = ^{sb_ld_addr[WORD_W-1:DM_IDX_HI+1], sb_ld_addr[DM_IDX_LO-1:0]};

  sb_fwd_select #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .valid_i   (valid),
    .entries_i (mem_q),
    .tail_i    (tail_q),
    .ld_idx_i  (ld_idx),
    .hit_o     (sb_ld_hit),
    .data_o    (sb_ld_data)
  );

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the ALU/store path and the data memory.
- sw instructions push {address, data} into a small FIFO and complete in the cycle they issue.
- The buffer drains one entry per cycle into the data memory write port when memory is ready.
- lw addresses are checked against buffered stores; the youngest match forwards its data so loads never observe stale memory.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_sb  in  1  asynchronous, active-high reset.
- sb_push  in  1  store issued this cycle (ctrl_dataMem_Write from control).
- sb_push_addr  in  32  store byte address (ALU result).
- sb_push_data  in  32  store data (rt value).
- sb_full  out  1  count == DEPTH; the core must stall sw while this is high.
- sb_empty  out  1  count == 0.
- sb_count  out  CNT_W  current occupancy.
- sb_overflow  out  1  sticky flag: a push arrived while full.
- sb_ld_addr  in  32  load byte address (ALU result).
- sb_ld_hit  out  1  a buffered store matches sb_ld_addr.
- sb_ld_data  out  32  data of the youngest matching entry; 0 when there is no hit.
- dm_ready  in  1  data memory can accept a write this cycle.
- dm_wr_en  out  1  write enable to data memory.
- dm_wr_addr  out  32  head entry address.
- dm_wr_data  out  32  head entry data.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high on rst_sb.
  - Reset clears head/tail pointers, count and sb_overflow; sb_empty=1, sb_full=0, dm_wr_en=0, sb_ld_hit=0, sb_ld_data=0.
  - Entry storage is not cleared.
  - Reset mid-operation discards all pending stores; no write to memory occurs afterwards.
- Push:
  - Accepted at a rising edge iff sb_push=1 and registered count < DEPTH.
  - The entry is written at tail, and tail advances modulo DEPTH.
  - A push while full is dropped, and sb_overflow is set until reset.
  - A simultaneous pop does not free a slot for the same edge's push. Acceptance depends only on the registered count, so there is no combinational path from dm_ready.
- Drain:
  - dm_wr_en = !sb_empty && dm_ready, combinational. dm_wr_addr/dm_wr_data are the head entry, valid whenever !sb_empty.
  - On an edge with dm_wr_en=1, the entry pops and head advances modulo DEPTH.
  - Minimum residency is one cycle: an entry pushed at edge N is written to memory at edge N+1 at the earliest.
- Count update:
  - push-only: +1.
  - pop-only: -1.
  - push and pop together: unchanged.
  - No underflow is possible.
- Forwarding:
  - Combinational over all valid entries, including the head being written this cycle.
  - Match on word index addr[9:2], the same aliasing as the data memory.
  - Youngest entry (closest to tail) wins.
  - No merging: repeated stores to the same address occupy separate entries.
  - A push in the current cycle is not visible to a load in the same cycle; the core must not issue both in one cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer compare.

Decomposition:
- Shared package mips_pkg:
  - WORD_W=32.
  - DM_IDX_HI=9, DM_IDX_LO=2.
  - typedef sb_entry_t {addr[31:0], data[31:0]}.
- One sub-module, sb_fwd_select:
  - Inputs: valid vector, entries, tail pointer, load word index.
  - Outputs: hit plus youngest-match data, via a priority search from tail-1 backwards.

Test Plan:
1. Reset with dm_ready=1, then push addr=0x10, data=0xDEADBEEF: count=1 after the edge; next cycle dm_wr_en=1, dm_wr_addr=0x10, dm_wr_data=0xDEADBEEF; after that edge count=0, sb_empty=1.
2. dm_ready=0, push 4 stores (0x00..0x0C, data 1..4): sb_full=1; a 5th push sets sb_overflow=1 and count stays 4; dm_ready=1 drains data 1,2,3,4 in order over 4 cycles.
3. dm_ready=0, push (0x20,0xAAAA) then (0x20,0xBBBB); sb_ld_addr=0x20 gives hit=1, data=0xBBBB; sb_ld_addr=0x420 (same [9:2]) hits; 0x24 gives hit=0, data=0.
4. count=2, push and pop in the same cycle: count stays 2, tail and head both advance; repeat 6 times to cross the pointer wrap, and drain order stays correct.
5. count=4, dm_ready=1, push in the same cycle: the push is dropped (overflow=1) and the pop completes, so count=3.
6. Assert rst_sb mid-drain with count=3: outputs go to reset values immediately, with no further dm_wr_en pulses.
